seq_detect_param: RTL and testbench

Parametrised serial bit-sequence detector for the sequential-logic FSM blocks. It generalises the fixed "0 then 1" detector to a runtime-loadable pattern of 1..PAT_W bits, with an input-valid qualifier, selectable overlapping or non-overlapping detection, and a saturating match counter. It sits after a serial bit source such as a deserialiser or a test stimulus shifter, and drives a one-cycle registered match pulse to downstream control logic.

---
 rtl/seq_detect_param.sv | 113 +++++++++++
 tb/tb_seq_detect_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial bit-sequence detector with a runtime-loadable pattern of 1..PAT_W bits,
// optional overlapping detection and a saturating match counter.
module seq_detect_param #(
  parameter int unsigned      PAT_W   = 8,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(2'b01),
  parameter int unsigned      DEF_LEN = 2,
  parameter bit               DEF_OVL = 1'b1,
  parameter int unsigned      LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_cfg_load,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_overlap,
  input  logic             i_valid,
  input  logic             i_seq,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt
);

  localparam logic [LEN_W-1:0] PatWLen = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [PAT_W-1:0] cfg_pat_q, cfg_pat_d;
  logic [LEN_W-1:0] cfg_len_q, cfg_len_d;
  logic             cfg_ovl_q, cfg_ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LEN_W-1:0] eff_len;
  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] next_hist;
  logic [LEN_W-1:0] next_fill;
  logic             hit;

  assign eff_len   = (cfg_len_q > PatWLen) ? PatWLen : cfg_len_q;
  assign next_hist = {hist_q[PAT_W-2:0], i_seq};
  assign next_fill = (fill_q >= PatWLen) ? PatWLen : fill_q + LEN_W'(1);

  // Only the low eff_len history bits take part in the comparison.
  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < eff_len);
    end
  end

  assign hit = (eff_len != '0) && (next_fill >= eff_len) &&
               (((next_hist ^ cfg_pat_q) & mask) == '0);

  always_comb begin
    cfg_pat_d = cfg_pat_q;
    cfg_len_d = cfg_len_q;
    cfg_ovl_d = cfg_ovl_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = 1'b0;
    cnt_d     = cnt_q;
    if (i_clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (i_cfg_load) begin
      cfg_pat_d = i_pattern;
      cfg_len_d = i_len;
      cfg_ovl_d = i_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (i_valid) begin
      hist_d  = next_hist;
      fill_d  = next_fill;
      match_d = hit;
      if (hit) begin
        // Non-overlapping mode demands L fresh bits before the next match.
        if (!cfg_ovl_q) begin
          fill_d = '0;
        end
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cfg_pat_q <= DEF_PAT;
      cfg_len_q <= LEN_W'(DEF_LEN);
      cfg_ovl_q <= DEF_OVL;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      cfg_pat_q <= cfg_pat_d;
      cfg_len_q <= cfg_len_d;
      cfg_ovl_q <= cfg_ovl_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_match     = match_q;
  assign o_match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: a wide-counter and a 2-bit-counter instance share stimulus;
// a bit-queue reference model feeds a scoreboard compared one edge later.
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  typedef struct {
    bit m;
    int ca;
    int cb;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rstn = 1'b0;
  logic             i_clr = 1'b0;
  logic             i_cfg_load = 1'b0;
  logic [PAT_W-1:0] i_pattern = '0;
  logic [LEN_W-1:0] i_len = '0;
  logic             i_overlap = 1'b0;
  logic             i_valid = 1'b0;
  logic             i_seq = 1'b0;
  logic             match_a, match_b;
  logic [7:0]       cnt_a;
  logic [1:0]       cnt_b;

  seq_detect_param #(.PAT_W(8), .CNT_W(8)) dut_a (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(i_clr), .i_cfg_load(i_cfg_load),
    .i_pattern(i_pattern), .i_len(i_len), .i_overlap(i_overlap), .i_valid(i_valid),
    .i_seq(i_seq), .o_match(match_a), .o_match_cnt(cnt_a)
  );

  seq_detect_param #(.PAT_W(8), .CNT_W(2)) dut_b (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_clr(i_clr), .i_cfg_load(i_cfg_load),
    .i_pattern(i_pattern), .i_len(i_len), .i_overlap(i_overlap), .i_valid(i_valid),
    .i_seq(i_seq), .o_match(match_b), .o_match_cnt(cnt_b)
  );

  always #5 i_clk = ~i_clk;

  int         n_checks = 0;
  int         n_pass = 0;
  int         pulses = 0;
  string      phase = "reset";
  exp_t       sb[$];
  bit         bits[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  int         ca, cb;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d", phase, tag, got, exp);
  endtask

  task automatic model_reset();
    m_pat = 8'b01;
    m_len = 2;
    m_ovl = 1'b1;
    bits.delete();
    ca = 0;
    cb = 0;
  endtask

  task automatic step(input bit clr, input bit load, input bit valid, input bit sq);
    exp_t e;
    bit   hit;
    int   l;
    i_clr      = clr;
    i_cfg_load = load;
    i_valid    = valid;
    i_seq      = sq;
    hit = 1'b0;
    if (clr) begin
      bits.delete();
      ca = 0;
      cb = 0;
    end else if (load) begin
      m_pat = i_pattern;
      m_len = int'(i_len);
      m_ovl = i_overlap;
      bits.delete();
    end else if (valid) begin
      bits.push_back(sq);
      if (bits.size() > PAT_W) void'(bits.pop_front());
      l = (m_len > PAT_W) ? PAT_W : m_len;
      if (l > 0 && bits.size() >= l) begin
        hit = 1'b1;
        for (int k = 0; k < l; k++) if (bits[bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit) begin
        if (ca < 255) ca++;
        if (cb < 3) cb++;
        if (!m_ovl) bits.delete();
      end
    end
    e.m  = hit;
    e.ca = ca;
    e.cb = cb;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    if (match_a) pulses++;
    check("match_a", int'(match_a), int'(e.m));
    check("match_b", int'(match_b), int'(e.m));
    check("cnt_a", int'(cnt_a), e.ca);
    check("cnt_b", int'(cnt_b), e.cb);
    i_clr      = 1'b0;
    i_cfg_load = 1'b0;
    i_valid    = 1'b0;
  endtask

  task automatic stream(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, v[i]);
  endtask

  task automatic load(input logic [7:0] pat, input int len, input bit ovl);
    i_pattern = pat;
    i_len     = LEN_W'(len);
    i_overlap = ovl;
    step(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    i_rstn = 1'b0;
    #2;
    model_reset();
    check("rst_match", int'(match_a), 0);
    check("rst_cnt_a", int'(cnt_a), 0);
    check("rst_cnt_b", int'(cnt_b), 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    do_reset();

    phase = "default"; pulses = 0;
    stream(16'b01101, 5);
    check("pulses", pulses, 2);
    check("cnt", int'(cnt_a), 2);

    phase = "ovl_on"; step(1'b1, 1'b0, 1'b0, 1'b0); load(8'b1011, 4, 1'b1); pulses = 0;
    stream(16'b1011011, 7);
    check("pulses", pulses, 2);
    check("cnt", int'(cnt_a), 2);

    phase = "ovl_off"; step(1'b1, 1'b0, 1'b0, 1'b0); load(8'b1011, 4, 1'b0); pulses = 0;
    stream(16'b1011011, 7);
    check("pulses", pulses, 1);
    check("cnt", int'(cnt_a), 1);

    phase = "gaps"; step(1'b1, 1'b0, 1'b0, 1'b0); load(8'b1011, 4, 1'b1); pulses = 0;
    begin
      logic [6:0] s;
      s = 7'b1011011;
      for (int i = 6; i >= 0; i--) begin
        step(1'b0, 1'b0, 1'b1, s[i]);
        step(1'b0, 1'b0, 1'b0, ~s[i]);
      end
    end
    check("pulses", pulses, 2);
    check("cnt", int'(cnt_a), 2);

    phase = "clr_last"; pulses = 0;
    stream(16'b101, 3);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    stream(16'b1, 1);
    check("pulses", pulses, 0);
    check("cnt", int'(cnt_a), 0);

    phase = "load_mid"; pulses = 0;
    stream(16'b101, 3);
    load(8'b1011, 4, 1'b1);
    stream(16'b1, 1);
    check("pulses_a", pulses, 0);
    stream(16'b011, 3);
    check("pulses_b", pulses, 1);

    phase = "saturate"; step(1'b1, 1'b0, 1'b0, 1'b0); load(8'b1, 1, 1'b1); pulses = 0;
    stream(16'b11111, 5);
    check("pulses", pulses, 5);
    check("cnt_b", int'(cnt_b), 3);
    check("cnt_a", int'(cnt_a), 5);

    phase = "len0"; load(8'b0, 0, 1'b1); pulses = 0;
    stream(16'b1100, 4);
    check("pulses", pulses, 0);

    phase = "len9"; load(8'b1010_1010, 9, 1'b1); pulses = 0;
    stream(16'b10_1010_1010, 10);
    check("pulses", pulses, 2);

    phase = "zeros"; load(8'b0, 3, 1'b1); pulses = 0;
    stream(16'b0000, 4);
    check("pulses", pulses, 2);

    phase = "async_rst"; load(8'b1011, 4, 1'b1);
    stream(16'b101, 3);
    do_reset();
    pulses = 0;
    stream(16'b101, 3);
    check("pulses", pulses, 1);

    phase = "random";
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) step(1'b1, 1'b0, 1'b1, 1'($urandom));
      else if (r < 6) load(8'($urandom), int'($urandom_range(0, 9)), 1'($urandom));
      else step(1'b0, 1'b0, (r % 5) != 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
